efpga_coproc_responder: RTL and testbench
=========================================

Name: efpga_coproc_responder

Overview:
- Fabric-side responder for the core's eFPGA coprocessor port. It accepts operands, an operator and a delay on a write strobe, then waits a programmable latency.
- It then presents three 32-bit results and holds fpga_done high until the next accepted strobe.
- It stands in for the eFPGA user logic in simulation and hardened bring-up. It connects directly to the core's eFPGA_* pins.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- DELAY_W, 4, width of the delay field.
- EXTRA_LAT, 0, cycles added to every operation's latency (0..3).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset: one clock; reset is asynchronous and active-low.
- eFPGA_en_i  in  1  coprocessor enable from the core.
- eFPGA_write_strobe_i  in  1  one-cycle request strobe.
- eFPGA_operand_a_i  in  32  operand A.
- eFPGA_operand_b_i  in  32  operand B.
- eFPGA_operator_i  in  2  operation select.
- eFPGA_delay_i  in  4  requested extra latency.
- eFPGA_result_a_o  out  32  result A.
- eFPGA_result_b_o  out  32  result B.
- eFPGA_result_c_o  out  32  result C.
- eFPGA_fpga_done_o  out  1  results valid (level).
- overrun_o  out  1  one-cycle pulse when a strobe is dropped while busy.
- busy_o  out  1  high in BUSY.

Behaviour:
- Reset values: all results 0, done 0, overrun 0, busy 0, accumulator 0, MAC count 0, state IDLE.
- States:
  - IDLE: no result pending.
  - BUSY: down-counter running.
  - DONE: results valid.
- Accept condition: en_i & write_strobe_i in IDLE or DONE.
  - On accept, latch a, b, op and delay. Load cnt = delay_i + EXTRA_LAT.
  - Drop done the next cycle and go to BUSY.
- BUSY: cnt decrements each cycle. When cnt==0 the same cycle computes results from the latched operands; register them, set done, go to DONE.
- Latency: done rises delay_i+EXTRA_LAT+1 cycles after the accept edge. delay=0, EXTRA_LAT=0 gives done on the 1st cycle after the strobe. delay=15 gives the 16th.
- Results and done stay stable in DONE until the next accept or an abort.
- Operations (all unsigned, modulo 2^32 unless noted):
  - 00 ADD: res_a = a+b; res_b = carry-out in bit 0; res_c = a-b.
  - 01 MUL: {res_b,res_a} = a*b (64-bit product); res_c = a^b.
  - 10 MAC: res_b = old acc; acc = acc + low32(a*b); res_a = new acc; mac_cnt++ (wraps); res_c = new mac_cnt. Accumulator and count update only at completion.
  - 11 CLR: acc = 0; mac_cnt = 0; res_a = old acc; res_b = old mac_cnt; res_c = 0.
- Strobe while BUSY: ignored (latched values unchanged); overrun_o pulses one cycle.
- Strobe with en_i low: ignored; no overrun pulse.
- en_i deasserted in BUSY: abort to IDLE next cycle.
  - done stays 0; results keep prior values; acc and mac_cnt are untouched.
- en_i deasserted in DONE: go to IDLE; done drops; results hold.
- Strobe on the same cycle as BUSY completion: counts as busy → overrun; done still rises.
- Asynchronous reset mid-operation: immediate return to reset values.

Decomposition:
- Package efpga_pkg holds:
  - the operator enum (OP_ADD, OP_MUL, OP_MAC, OP_CLR);
  - the state enum (ST_IDLE, ST_BUSY, ST_DONE);
  - DATA_W and DELAY_W constants.
- Sub-module efpga_alu is purely combinational. It takes latched a, b, op, acc and mac_cnt, and produces res_a/b/c, next acc and next mac_cnt.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Reset then ADD, a=0xFFFFFFFF, b=2, delay=0, en=1 → done on cycle +1; res_a=0x00000001, res_b=1, res_c=0xFFFFFFFD.
- MUL, a=0x10000, b=0x10000, delay=5 → done exactly 6 cycles after the strobe; res_a=0, res_b=1, res_c=0; busy high for 6 cycles.
- MAC sequence: MAC(3,4), MAC(5,6), then CLR → res_a 12 then 42; res_c 1 then 2; CLR gives res_a=42, res_b=2; next MAC(1,1) gives res_a=1, res_c=1.
- Second strobe 2 cycles into a delay=8 op → overrun_o one-cycle pulse; first op's results unaffected; done at cycle +9.
- en_i dropped mid-BUSY (delay=10, drop at cycle 4) → state IDLE, done never rises, acc unchanged; a subsequent accept works normally.
- rst_ni asserted while in DONE with MAC acc=42 → all outputs 0 immediately; after release, MAC(2,3) gives res_a=6.

Source files
------------

// File: rtl/efpga_coproc_responder_pkg.sv
// Shared types and constants for the eFPGA coprocessor responder.
// Operator and FSM state encodings are used by the top and the ALU.
package efpga_pkg;

    localparam int DATA_W  = 32;
    localparam int DELAY_W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_MAC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/efpga_coproc_responder_if.sv
// Core-to-fabric eFPGA coprocessor pin bundle.
// The master modport is the core side; the slave modport is the responder.
interface efpga_coproc_if;

    logic                          eFPGA_en_i;
    logic                          eFPGA_write_strobe_i;
    logic [efpga_pkg::DATA_W-1:0]  eFPGA_operand_a_i;
    logic [efpga_pkg::DATA_W-1:0]  eFPGA_operand_b_i;
    logic [1:0]                    eFPGA_operator_i;
    logic [efpga_pkg::DELAY_W-1:0] eFPGA_delay_i;
    logic [efpga_pkg::DATA_W-1:0]  eFPGA_result_a_o;
    logic [efpga_pkg::DATA_W-1:0]  eFPGA_result_b_o;
    logic [efpga_pkg::DATA_W-1:0]  eFPGA_result_c_o;
    logic                          eFPGA_fpga_done_o;

    modport master (
        output eFPGA_en_i, eFPGA_write_strobe_i, eFPGA_operand_a_i,
               eFPGA_operand_b_i, eFPGA_operator_i, eFPGA_delay_i,
        input  eFPGA_result_a_o, eFPGA_result_b_o, eFPGA_result_c_o,
               eFPGA_fpga_done_o
    );

    modport slave (
        input  eFPGA_en_i, eFPGA_write_strobe_i, eFPGA_operand_a_i,
               eFPGA_operand_b_i, eFPGA_operator_i, eFPGA_delay_i,
        output eFPGA_result_a_o, eFPGA_result_b_o, eFPGA_result_c_o,
               eFPGA_fpga_done_o
    );

endinterface

// File: rtl/efpga_coproc_responder_alu.sv
// Combinational result generator: ADD/MUL/MAC/CLR on latched operands.
// Also produces the next accumulator and MAC count for the top to commit.
module efpga_alu
    import efpga_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  op_e               i_op,
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_mac_cnt,
    output logic [DATA_W-1:0] o_res_a,
    output logic [DATA_W-1:0] o_res_b,
    output logic [DATA_W-1:0] o_res_c,
    output logic [DATA_W-1:0] o_acc_nxt,
    output logic [DATA_W-1:0] o_mac_cnt_nxt
);

    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_acc_mac;
    logic [DATA_W-1:0]   w_cnt_inc;

    assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
    assign w_prod    = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign w_acc_mac = i_acc + w_prod[DATA_W-1:0];
    assign w_cnt_inc = i_mac_cnt + DATA_W'(1);

    always_comb begin
        o_res_a       = '0;
        o_res_b       = '0;
        o_res_c       = '0;
        o_acc_nxt     = i_acc;
        o_mac_cnt_nxt = i_mac_cnt;
        case (i_op)
            OP_ADD: begin
                o_res_a = w_sum[DATA_W-1:0];
                o_res_b = {{(DATA_W-1){1'b0}}, w_sum[DATA_W]};
                o_res_c = i_a - i_b;
            end
            OP_MUL: begin
                o_res_a = w_prod[DATA_W-1:0];
                o_res_b = w_prod[2*DATA_W-1:DATA_W];
                o_res_c = i_a ^ i_b;
            end
            OP_MAC: begin
                o_res_a       = w_acc_mac;
                o_res_b       = i_acc;
                o_res_c       = w_cnt_inc;
                o_acc_nxt     = w_acc_mac;
                o_mac_cnt_nxt = w_cnt_inc;
            end
            default: begin
                o_res_a       = i_acc;
                o_res_b       = i_mac_cnt;
                o_acc_nxt     = '0;
                o_mac_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/efpga_coproc_responder.sv
// eFPGA coprocessor responder: accepts a strobed request, waits a programmable
// latency, then presents three results with a level done until the next accept.
module efpga_coproc_responder #(
    parameter int DATA_W    = 32,
    parameter int DELAY_W   = 4,
    parameter int EXTRA_LAT = 0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    efpga_coproc_if.slave  bus,
    output logic           overrun_o,
    output logic           busy_o
);

    import efpga_pkg::*;

    // Two extra bits so delay + EXTRA_LAT (up to 3) never wraps.
    localparam int CNT_W = DELAY_W + 2;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    op_e                 r_op;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_mac_cnt;
    logic [DATA_W-1:0]   r_res_a;
    logic [DATA_W-1:0]   r_res_b;
    logic [DATA_W-1:0]   r_res_c;
    logic                r_done;
    logic                r_overrun;

    logic                w_req;
    logic                w_accept;
    logic                w_complete;
    logic                w_overrun;
    logic [DATA_W-1:0]   w_res_a;
    logic [DATA_W-1:0]   w_res_b;
    logic [DATA_W-1:0]   w_res_c;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [DATA_W-1:0]   w_mac_cnt_nxt;

    assign w_req = bus.eFPGA_en_i & bus.eFPGA_write_strobe_i;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A request landing on the completion cycle is still dropped.
                w_overrun = w_req;
                if (!bus.eFPGA_en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end else if (!bus.eFPGA_en_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    efpga_alu u_alu (
        .i_a           (r_a),
        .i_b           (r_b),
        .i_op          (r_op),
        .i_acc         (r_acc),
        .i_mac_cnt     (r_mac_cnt),
        .o_res_a       (w_res_a),
        .o_res_b       (w_res_b),
        .o_res_c       (w_res_c),
        .o_acc_nxt     (w_acc_nxt),
        .o_mac_cnt_nxt (w_mac_cnt_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_ADD;
            r_acc     <= '0;
            r_mac_cnt <= '0;
            r_res_a   <= '0;
            r_res_b   <= '0;
            r_res_c   <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (w_state_nxt == ST_DONE);
            r_overrun <= w_overrun;
            if (w_accept) begin
                r_a   <= bus.eFPGA_operand_a_i;
                r_b   <= bus.eFPGA_operand_b_i;
                r_op  <= op_e'(bus.eFPGA_operator_i);
                r_cnt <= CNT_W'(bus.eFPGA_delay_i) + CNT_W'(EXTRA_LAT);
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_complete) begin
                r_res_a   <= w_res_a;
                r_res_b   <= w_res_b;
                r_res_c   <= w_res_c;
                r_acc     <= w_acc_nxt;
                r_mac_cnt <= w_mac_cnt_nxt;
            end
        end
    end

    assign bus.eFPGA_result_a_o  = r_res_a;
    assign bus.eFPGA_result_b_o  = r_res_b;
    assign bus.eFPGA_result_c_o  = r_res_c;
    assign bus.eFPGA_fpga_done_o = r_done;
    assign overrun_o             = r_overrun;
    assign busy_o                = (r_state == ST_BUSY);

endmodule

// File: tb/tb_efpga_coproc_responder.sv
// Self-checking bench for efpga_coproc_responder: directed table, corner
// sequences and randomized operations against a behavioural model.
module tb_efpga_coproc_responder;

    import efpga_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic overrun;
    logic busy;

    always #5 clk = ~clk;

    efpga_coproc_if bus ();

    efpga_coproc_responder #(
        .DATA_W    (32),
        .DELAY_W   (4),
        .EXTRA_LAT (0)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .overrun_o (overrun),
        .busy_o    (busy)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] m_acc;
    logic [31:0] m_cnt;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  d;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: results straight from the operation definitions.
    function automatic void model_op(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] ea,
                                     output logic [31:0] eb, output logic [31:0] ec);
        logic [63:0] wide;
        ea = 0; eb = 0; ec = 0;
        case (op)
            2'd0: begin
                wide = {32'd0, a} + {32'd0, b};
                ea = wide[31:0];
                eb = {31'd0, wide[32]};
                ec = a - b;
            end
            2'd1: begin
                wide = {32'd0, a} * {32'd0, b};
                ea = wide[31:0];
                eb = wide[63:32];
                ec = a ^ b;
            end
            2'd2: begin
                eb    = m_acc;
                m_acc = m_acc + a * b;
                m_cnt = m_cnt + 1;
                ea    = m_acc;
                ec    = m_cnt;
            end
            default: begin
                ea = m_acc;
                eb = m_cnt;
                ec = 0;
                m_acc = 0;
                m_cnt = 0;
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] d);
        bus.eFPGA_operator_i     = op;
        bus.eFPGA_operand_a_i    = a;
        bus.eFPGA_operand_b_i    = b;
        bus.eFPGA_delay_i        = d;
        bus.eFPGA_write_strobe_i = 1'b1;
        @(posedge clk); #1;
        bus.eFPGA_write_strobe_i = 1'b0;
    endtask

    // Issue one op, then measure cycles-to-done and cycles with busy high.
    task automatic run_check(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] d, input logic [31:0] ea,
                             input logic [31:0] eb, input logic [31:0] ec);
        int lat;
        int nbusy;
        issue(op, a, b, d);
        lat   = 0;
        nbusy = (busy === 1'b1) ? 1 : 0;
        while (bus.eFPGA_fpga_done_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy === 1'b1) nbusy++;
        end
        check({name, ".latency"}, 32'(lat), 32'(d) + 32'd1);
        check({name, ".busy_cycles"}, 32'(nbusy), 32'(d) + 32'd1);
        check({name, ".res_a"}, bus.eFPGA_result_a_o, ea);
        check({name, ".res_b"}, bus.eFPGA_result_b_o, eb);
        check({name, ".res_c"}, bus.eFPGA_result_c_o, ec);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ea, eb, ec;
        logic [31:0] pa, pb, pc;
        int cyc;
        int first_done;
        bit saw_done;

        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'd2,       4'd0, 32'h0000_0001, 32'd1,  32'hFFFF_FFFD};
        tbl[1] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 4'd5, 32'd0,      32'd1,  32'd0};
        tbl[2] = '{2'd2, 32'd3,         32'd4,       4'd2, 32'd12,        32'd0,  32'd1};
        tbl[3] = '{2'd2, 32'd5,         32'd6,       4'd1, 32'd42,        32'd12, 32'd2};
        tbl[4] = '{2'd3, 32'd0,         32'd0,       4'd3, 32'd42,        32'd2,  32'd0};
        tbl[5] = '{2'd2, 32'd1,         32'd1,       4'd0, 32'd1,         32'd0,  32'd1};

        rst_n = 1'b0;
        bus.eFPGA_en_i = 1'b0;
        bus.eFPGA_write_strobe_i = 1'b0;
        bus.eFPGA_operand_a_i = '0;
        bus.eFPGA_operand_b_i = '0;
        bus.eFPGA_operator_i = '0;
        bus.eFPGA_delay_i = '0;
        m_acc = 0;
        m_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.done", {31'd0, bus.eFPGA_fpga_done_o}, 32'd0);
        check("reset.res_a", bus.eFPGA_result_a_o, 32'd0);
        check("reset.res_b", bus.eFPGA_result_b_o, 32'd0);
        check("reset.res_c", bus.eFPGA_result_c_o, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.overrun", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        bus.eFPGA_en_i = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            model_op(tbl[i].op, tbl[i].a, tbl[i].b, ea, eb, ec);
            run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d,
                      tbl[i].ea, tbl[i].eb, tbl[i].ec);
        end

        repeat (3) @(posedge clk);
        #1;
        check("hold.done", {31'd0, bus.eFPGA_fpga_done_o}, 32'd1);
        check("hold.res_a", bus.eFPGA_result_a_o, 32'd1);

        // Strobe on the completion cycle: dropped with overrun, done still rises.
        issue(OP_ADD, 32'd5, 32'd7, 4'd0);
        bus.eFPGA_operator_i = OP_MUL;
        bus.eFPGA_operand_a_i = 32'd9;
        bus.eFPGA_operand_b_i = 32'd9;
        bus.eFPGA_write_strobe_i = 1'b1;
        @(posedge clk); #1;
        bus.eFPGA_write_strobe_i = 1'b0;
        check("cmpl.done", {31'd0, bus.eFPGA_fpga_done_o}, 32'd1);
        check("cmpl.overrun", {31'd0, overrun}, 32'd1);
        check("cmpl.res_a", bus.eFPGA_result_a_o, 32'd12);
        check("cmpl.res_c", bus.eFPGA_result_c_o, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("cmpl.overrun_end", {31'd0, overrun}, 32'd0);
        check("cmpl.done_hold", {31'd0, bus.eFPGA_fpga_done_o}, 32'd1);

        // Second strobe two cycles into a delay=8 operation.
        issue(OP_ADD, 32'd10, 32'd3, 4'd8);
        cyc = 0;
        first_done = 0;
        while (first_done == 0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.eFPGA_fpga_done_o === 1'b1) first_done = cyc;
            if (cyc == 2) begin
                bus.eFPGA_operator_i = OP_MUL;
                bus.eFPGA_operand_a_i = 32'd100;
                bus.eFPGA_operand_b_i = 32'd100;
                bus.eFPGA_write_strobe_i = 1'b1;
            end
            if (cyc == 3) begin
                check("ovr.pulse", {31'd0, overrun}, 32'd1);
                bus.eFPGA_write_strobe_i = 1'b0;
            end
            if (cyc == 4) check("ovr.pulse_end", {31'd0, overrun}, 32'd0);
        end
        check("ovr.latency", 32'(first_done), 32'd9);
        check("ovr.res_a", bus.eFPGA_result_a_o, 32'd13);
        check("ovr.res_b", bus.eFPGA_result_b_o, 32'd0);
        check("ovr.res_c", bus.eFPGA_result_c_o, 32'd7);

        // Abort: en dropped four cycles into a delay=10 MAC.
        pa = bus.eFPGA_result_a_o;
        pb = bus.eFPGA_result_b_o;
        pc = bus.eFPGA_result_c_o;
        issue(OP_MAC, 32'd7, 32'd8, 4'd10);
        saw_done = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (bus.eFPGA_fpga_done_o === 1'b1) saw_done = 1'b1;
            if (c == 4) bus.eFPGA_en_i = 1'b0;
            if (c == 5) check("abort.busy", {31'd0, busy}, 32'd0);
        end
        check("abort.no_done", {31'd0, saw_done}, 32'd0);
        check("abort.res_a", bus.eFPGA_result_a_o, pa);
        check("abort.res_b", bus.eFPGA_result_b_o, pb);
        check("abort.res_c", bus.eFPGA_result_c_o, pc);
        bus.eFPGA_en_i = 1'b1;
        model_op(OP_MAC, 32'd1, 32'd2, ea, eb, ec);
        run_check("post_abort", OP_MAC, 32'd1, 32'd2, 4'd0, ea, eb, ec);

        // en low in DONE returns to IDLE; strobes with en low do nothing.
        pa = bus.eFPGA_result_a_o;
        bus.eFPGA_en_i = 1'b0;
        @(posedge clk); #1;
        check("enlow.done", {31'd0, bus.eFPGA_fpga_done_o}, 32'd0);
        check("enlow.res_hold", bus.eFPGA_result_a_o, pa);
        bus.eFPGA_write_strobe_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.eFPGA_write_strobe_i = 1'b0;
        check("enlow.overrun", {31'd0, overrun}, 32'd0);
        check("enlow.busy", {31'd0, busy}, 32'd0);
        bus.eFPGA_en_i = 1'b1;

        for (int i = 0; i < 30; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            logic [3:0]  d;
            op = 2'($urandom_range(0, 3));
            a  = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
            b  = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
            d  = 4'($urandom_range(0, 15));
            model_op(op, a, b, ea, eb, ec);
            run_check($sformatf("rnd%0d", i), op, a, b, d, ea, eb, ec);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check($sformatf("rnd%0d.hold", i), bus.eFPGA_result_a_o, ea);
        end

        // Asynchronous reset while in DONE with acc=42.
        model_op(OP_CLR, 32'd0, 32'd0, ea, eb, ec);
        run_check("pre_rst_clr", OP_CLR, 32'd0, 32'd0, 4'd1, ea, eb, ec);
        model_op(OP_MAC, 32'd6, 32'd7, ea, eb, ec);
        run_check("pre_rst_mac", OP_MAC, 32'd6, 32'd7, 4'd2, 32'd42, 32'd0, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.done", {31'd0, bus.eFPGA_fpga_done_o}, 32'd0);
        check("arst.res_a", bus.eFPGA_result_a_o, 32'd0);
        check("arst.res_b", bus.eFPGA_result_b_o, 32'd0);
        check("arst.res_c", bus.eFPGA_result_c_o, 32'd0);
        check("arst.busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk); #1;
        model_op(OP_MAC, 32'd2, 32'd3, ea, eb, ec);
        run_check("post_rst_mac", OP_MAC, 32'd2, 32'd3, 4'd0, 32'd6, 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
